// File: rtl/ssi_pkg.sv
// Shared types and helpers for the SSI encoder master.
package ssi_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    CLOCKING   = 2'd2,
    MONO       = 2'd3
  } state_t;

  // Gray-to-binary conversion. The field is zero-extended to 64 bits, so the
  // leading zeros decode to zeros. The low bits therefore equal the decode of
  // a field of any width <= 64.
  function automatic logic [63:0] gray2bin(input logic [63:0] g);
    logic [63:0] b;
    b[63] = g[63];
    for (int i = 62; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ssi_clk_gen.sv
// Encoder clock generator: half-period timing, enc_clk toggling, sample
// strobe on the last cycle of each high phase, and frame-bit counting.
module ssi_clk_gen import ssi_pkg::*; #(
  parameter int FRAME_BITS = 24,
  parameter int CLK_DIV    = 8
) (
  input  logic sck,
  input  logic rst_n,
  input  logic go,
  input  logic run,
  output logic enc_clk,
  output logic sample,
  output logic frame_done
);

  localparam int HC_W = $clog2(CLK_DIV) + 1;
  localparam int BC_W = $clog2(FRAME_BITS) + 1;

  logic [HC_W-1:0] half_cnt;
  logic [BC_W-1:0] bit_cnt;
  logic            half_last;

  assign half_last  = (half_cnt == HC_W'(CLK_DIV - 1));
  assign sample     = run && enc_clk && half_last;
  assign frame_done = sample && (bit_cnt == BC_W'(FRAME_BITS - 1));

  // Half-period counter and enc_clk; enc_clk stays high after the final sample
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      enc_clk  <= 1'b1;
      half_cnt <= '0;
      bit_cnt  <= '0;
    end else if (go) begin
      enc_clk  <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
    end else if (run) begin
      if (half_last) begin
        half_cnt <= '0;
        if (!enc_clk) begin
          enc_clk <= 1'b1;
        end else if (!frame_done) begin
          enc_clk <= 1'b0;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end else begin
      enc_clk  <= 1'b1;
      half_cnt <= '0;
    end
  end

endmodule

// File: rtl/ssi_encoder_master.sv
// SSI master for absolute rotary encoders: request handling, ready wait,
// frame capture, monoflop check and position extraction.
module ssi_encoder_master import ssi_pkg::*; #(
  parameter int FRAME_BITS    = 24,
  parameter int POS_MSB       = 21,
  parameter int POS_LSB       = 3,
  parameter int CLK_DIV       = 8,
  parameter int MONO_CYCLES   = 200,
  parameter int READY_TIMEOUT = 1000,
  parameter int PERIOD        = 2000,
  parameter int GRAY          = 1
) (
  input  logic                     sck,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     auto_en,
  input  logic                     miso,
  output logic                     enc_clk,
  output logic [POS_MSB-POS_LSB:0] encoder_val,
  output logic                     data_valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int POS_W   = POS_MSB - POS_LSB + 1;
  localparam int PT_W    = $clog2(PERIOD) + 1;
  localparam int CNT_MAX = (READY_TIMEOUT > MONO_CYCLES) ? READY_TIMEOUT : MONO_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t                  state;
  logic                    miso_m, miso_s;
  logic [PT_W-1:0]         per_cnt;
  logic                    per_exp;
  logic                    req;
  logic [CNT_W-1:0]        cnt;
  logic                    mono_done;
  logic [FRAME_BITS-1:0]   shift;
  logic [POS_W-1:0]        field;
  logic [63:0]             dec64;
  logic                    go, run, sample, frame_done;
  logic                    unused_bits;

  assign per_exp = auto_en && (per_cnt == PT_W'(PERIOD - 1));
  assign req     = start || per_exp;
  assign go      = ((state == IDLE) && req && miso_s) || ((state == WAIT_READY) && miso_s);
  assign run     = (state == CLOCKING);
  assign field   = shift[POS_MSB:POS_LSB];
  assign dec64   = (GRAY != 0) ? gray2bin(64'(field)) : 64'(field);
  assign unused_bits = ^{dec64[63:POS_W], shift};

  ssi_clk_gen #(
    .FRAME_BITS (FRAME_BITS),
    .CLK_DIV    (CLK_DIV)
  ) u_clk_gen (
    .sck        (sck),
    .rst_n      (rst_n),
    .go         (go),
    .run        (run),
    .enc_clk    (enc_clk),
    .sample     (sample),
    .frame_done (frame_done)
  );

  // Two-flop synchroniser for the asynchronous encoder data line
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      miso_m <= 1'b0;
      miso_s <= 1'b0;
    end else begin
      miso_m <= miso;
      miso_s <= miso_m;
    end
  end

  // Auto-mode period timer: free-runs while enabled, reloads on expiry
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (!auto_en || per_exp) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // Acquisition FSM; the result cycle is spent in MONO so requests there drop
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      encoder_val <= '0;
      shift       <= '0;
      cnt         <= '0;
      mono_done   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sample) begin
        shift <= {shift[FRAME_BITS-2:0], miso_s};
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            busy  <= 1'b1;
            state <= miso_s ? CLOCKING : WAIT_READY;
          end
        end
        WAIT_READY: begin
          if (miso_s) begin
            state <= CLOCKING;
            cnt   <= '0;
          end else if (cnt == CNT_W'(READY_TIMEOUT - 1)) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLOCKING: begin
          if (frame_done) begin
            state     <= MONO;
            cnt       <= '0;
            mono_done <= 1'b0;
          end
        end
        MONO: begin
          if (mono_done) begin
            mono_done <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (cnt == CNT_W'(MONO_CYCLES - 1)) begin
            mono_done <= 1'b1;
            if (miso_s) begin
              encoder_val <= dec64[POS_W-1:0];
              data_valid  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssi_encoder_master.sv
// Directed bench for ssi_encoder_master: a binary and a Gray instance share
// the same stimulus and a simple encoder model that drives miso.
module tb_ssi_encoder_master;

  localparam int FB = 24;
  localparam int CD = 8;

  logic        sck = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic        miso = 1'b1;
  logic        enc_clk, data_valid, frame_err, busy;
  logic [18:0] encoder_val;
  logic        enc_clk_g, data_valid_g, frame_err_g, busy_g;
  logic [18:0] encoder_val_g;

  int total = 0;
  int bad = 0;

  // encoder model state
  logic [FB-1:0] frame_word = '0;
  int            bit_idx = FB - 1;
  int            falls = 0;
  int            hi_cnt = 0;
  logic          mono_level = 1'b1;
  logic          prev_enc = 1'b1;

  // per-frame capture
  int   dv_cnt, dv_at, dv_first, err_cnt, err_at, lows, badw, busy_drop, run_len;
  logic enc1, busy1, enc_low_seen;

  ssi_encoder_master #(.GRAY(0)) dut (
    .sck(sck), .rst_n(rst_n), .start(start), .auto_en(auto_en), .miso(miso),
    .enc_clk(enc_clk), .encoder_val(encoder_val), .data_valid(data_valid),
    .frame_err(frame_err), .busy(busy)
  );

  ssi_encoder_master #(.GRAY(1)) dut_g (
    .sck(sck), .rst_n(rst_n), .start(start), .auto_en(auto_en), .miso(miso),
    .enc_clk(enc_clk_g), .encoder_val(encoder_val_g), .data_valid(data_valid_g),
    .frame_err(frame_err_g), .busy(busy_g)
  );

  always #5 sck = ~sck;

  // Advance one cycle (observe on falling edge) and run the encoder model:
  // new bit on each enc_clk fall, monoflop level once the frame has ended.
  task automatic tick();
    @(negedge sck);
    if (prev_enc && !enc_clk) begin
      miso = frame_word[bit_idx];
      bit_idx--;
      falls++;
    end else if (falls == FB && enc_clk) begin
      hi_cnt++;
      if (hi_cnt == CD + 1) begin
        miso = mono_level;
        falls = 0;
        hi_cnt = 0;
        bit_idx = FB - 1;
      end
    end
    prev_enc = enc_clk;
  endtask

  task automatic clear_capture();
    dv_cnt = 0; dv_at = -1; dv_first = -1; err_cnt = 0; err_at = -1;
    lows = 0; badw = 0; busy_drop = -1; run_len = 0; enc_low_seen = 1'b0;
    enc1 = 1'b1; busy1 = 1'b0;
  endtask

  task automatic capture(input int c);
    if (c == 1) begin enc1 = enc_clk; busy1 = busy; end
    if (data_valid) begin dv_cnt++; dv_at = c; if (dv_first < 0) dv_first = c; end
    if (frame_err) begin err_cnt++; err_at = c; end
    if (!busy && busy_drop < 0) busy_drop = c;
    if (!enc_clk) begin run_len++; enc_low_seen = 1'b1; end
    else if (run_len > 0) begin lows++; if (run_len != CD) badw++; run_len = 0; end
  endtask

  // One start-triggered frame; rise_at >= 0 holds miso low at the request
  // and lets miso_s rise at that cycle.
  task automatic run_frame(input logic [FB-1:0] fw, input logic ml, input int rise_at, input int ncyc);
    frame_word = fw; mono_level = ml; bit_idx = FB - 1; falls = 0; hi_cnt = 0;
    if (rise_at >= 0) begin miso = 1'b0; tick(); tick(); tick(); end
    tick();
    start = 1'b1;
    clear_capture();
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      start = 1'b0;
      capture(c);
      if (rise_at >= 0 && c == rise_at - 2) miso = 1'b1;
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (enc_clk !== 1'b1) begin bad++; $display("FAIL reset_enc_clk: got %b want 1", enc_clk); end
    total++; if (encoder_val !== 19'h0) begin bad++; $display("FAIL reset_val: got %h want 0", encoder_val); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv: got %b want 0", data_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_binary_frame();
    run_frame(24'hA5F0C3, 1'b1, -1, 600);
    total++; if (dv_cnt != 1) begin bad++; $display("FAIL bin_dv_count: got %0d want 1", dv_cnt); end
    total++; if (dv_at != 585) begin bad++; $display("FAIL bin_dv_cycle: got %0d want 585", dv_at); end
    total++; if (encoder_val !== 19'h4BE18) begin bad++; $display("FAIL bin_value: got %h want 4be18", encoder_val); end
    total++; if (lows != 24) begin bad++; $display("FAIL bin_low_pulses: got %0d want 24", lows); end
    total++; if (badw != 0) begin bad++; $display("FAIL bin_low_width: got %0d bad widths want 0", badw); end
    total++; if (enc1 !== 1'b0) begin bad++; $display("FAIL bin_enc_c1: got %b want 0", enc1); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL bin_busy_c1: got %b want 1", busy1); end
    total++; if (busy_drop != 586) begin bad++; $display("FAIL bin_busy_drop: got %0d want 586", busy_drop); end
    total++; if (err_cnt != 0) begin bad++; $display("FAIL bin_err_count: got %0d want 0", err_cnt); end
  endtask

  task automatic test_gray();
    run_frame(24'h200000, 1'b1, -1, 600);
    total++; if (encoder_val_g !== 19'h7FFFF) begin bad++; $display("FAIL gray_msb: got %h want 7ffff", encoder_val_g); end
    total++; if (encoder_val !== 19'h40000) begin bad++; $display("FAIL gray_msb_bin: got %h want 40000", encoder_val); end
    total++; if (dv_at != 585) begin bad++; $display("FAIL gray_dv_cycle: got %0d want 585", dv_at); end
    run_frame(24'h000018, 1'b1, -1, 600);
    total++; if (encoder_val_g !== 19'h00002) begin bad++; $display("FAIL gray_low: got %h want 2", encoder_val_g); end
    total++; if (encoder_val !== 19'h00003) begin bad++; $display("FAIL gray_low_bin: got %h want 3", encoder_val); end
  endtask

  task automatic test_mono_fail();
    run_frame(24'hA5F0C3, 1'b0, -1, 600);
    total++; if (err_cnt != 1) begin bad++; $display("FAIL mono_err_count: got %0d want 1", err_cnt); end
    total++; if (err_at != 585) begin bad++; $display("FAIL mono_err_cycle: got %0d want 585", err_at); end
    total++; if (dv_cnt != 0) begin bad++; $display("FAIL mono_dv_count: got %0d want 0", dv_cnt); end
    total++; if (encoder_val !== 19'h00003) begin bad++; $display("FAIL mono_hold: got %h want 3", encoder_val); end
    miso = 1'b1; mono_level = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_ready();
    run_frame(24'hA5F0C3, 1'b1, 100000, 1010);
    total++; if (err_at != 1001) begin bad++; $display("FAIL ready_err_cycle: got %0d want 1001", err_at); end
    total++; if (err_cnt != 1) begin bad++; $display("FAIL ready_err_count: got %0d want 1", err_cnt); end
    total++; if (dv_cnt != 0) begin bad++; $display("FAIL ready_dv_count: got %0d want 0", dv_cnt); end
    total++; if (enc_low_seen !== 1'b0) begin bad++; $display("FAIL ready_enc_toggle: got %b want 0", enc_low_seen); end
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL ready_busy_c1: got %b want 1", busy1); end
    total++; if (busy_drop != 1001) begin bad++; $display("FAIL ready_busy_drop: got %0d want 1001", busy_drop); end
    miso = 1'b1;
    tick(); tick(); tick();
    run_frame(24'hA5F0C3, 1'b1, 50, 700);
    total++; if (dv_at != 635) begin bad++; $display("FAIL late_dv_cycle: got %0d want 635", dv_at); end
    total++; if (dv_cnt != 1) begin bad++; $display("FAIL late_dv_count: got %0d want 1", dv_cnt); end
    total++; if (encoder_val !== 19'h4BE18) begin bad++; $display("FAIL late_value: got %h want 4be18", encoder_val); end
    total++; if (lows != 24) begin bad++; $display("FAIL late_low_pulses: got %0d want 24", lows); end
  endtask

  task automatic test_auto();
    frame_word = 24'hA5F0C3; mono_level = 1'b1; bit_idx = FB - 1; falls = 0; hi_cnt = 0;
    clear_capture();
    tick();
    auto_en = 1'b1;
    for (int j = 1; j <= 1999; j++) begin
      tick();
      capture(j);
    end
    start = 1'b1;
    for (int j = 2000; j <= 4700; j++) begin
      tick();
      start = 1'b0;
      capture(j);
    end
    auto_en = 1'b0;
    total++; if (dv_cnt != 2) begin bad++; $display("FAIL auto_dv_count: got %0d want 2", dv_cnt); end
    total++; if (dv_first != 2584) begin bad++; $display("FAIL auto_first: got %0d want 2584", dv_first); end
    total++; if (dv_at != 4584) begin bad++; $display("FAIL auto_second: got %0d want 4584", dv_at); end
    total++; if (err_cnt != 0) begin bad++; $display("FAIL auto_err_count: got %0d want 0", err_cnt); end
    total++; if (encoder_val !== 19'h4BE18) begin bad++; $display("FAIL auto_value: got %h want 4be18", encoder_val); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic enc_before;
    frame_word = 24'hA5F0C3; mono_level = 1'b1; bit_idx = FB - 1; falls = 0; hi_cnt = 0;
    tick();
    start = 1'b1;
    enc_before = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      start = 1'b0;
      if (c == 100) enc_before = enc_clk;
    end
    total++; if (enc_before !== 1'b0) begin bad++; $display("FAIL rmid_enc_before: got %b want 0", enc_before); end
    rst_n = 1'b0;
    #1;
    total++; if (enc_clk !== 1'b1) begin bad++; $display("FAIL rmid_enc: got %b want 1", enc_clk); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    clear_capture();
    for (int c = 1; c <= 5; c++) begin
      tick();
      capture(c);
    end
    total++; if (dv_cnt + err_cnt != 0) begin bad++; $display("FAIL rmid_pulse: got %0d pulses want 0", dv_cnt + err_cnt); end
    miso = 1'b1; falls = 0; hi_cnt = 0; bit_idx = FB - 1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    run_frame(24'hA5F0C3, 1'b1, -1, 600);
    total++; if (dv_at != 585) begin bad++; $display("FAIL rmid_dv_cycle: got %0d want 585", dv_at); end
    total++; if (encoder_val !== 19'h4BE18) begin bad++; $display("FAIL rmid_value: got %h want 4be18", encoder_val); end
  endtask

  initial begin
    test_reset();
    test_binary_frame();
    test_gray();
    test_mono_fail();
    test_ready();
    test_auto();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
